// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a word FIFO; each entry carries its own length/parity/stop format.
// Start bit appears two edges after a send into an idle block; sends into a full FIFO are dropped and flagged.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        i_clock,
    input  logic                        i_rst,
    input  logic                        i_send,
    input  logic [DATA_WIDTH-1:0]       i_data_in,
    input  logic [3:0]                  i_data_length,
    input  logic [1:0]                  i_parity_type,
    input  logic                        i_stop_bits,
    output logic                        o_data_out,
    output logic                        o_p_parity_out,
    output logic                        o_tx_active,
    output logic                        o_tx_done,
    output logic                        o_fifo_full,
    output logic                        o_fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
    output logic                        o_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LEN_MIN   = 4'd5;
    localparam logic [3:0]    LEN_MAX   = 4'(DATA_WIDTH);

    typedef struct packed {
        logic                  stop2;
        logic [1:0]            par;
        logic [3:0]            len;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    entry_t                r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;

    state_t                r_state;
    logic [TW-1:0]         r_timer;
    logic [3:0]            r_bit_cnt;
    logic [3:0]            r_len;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_en;
    logic                  r_two_stop;
    logic                  r_stop_cnt;
    logic                  r_data_out;
    logic                  r_p_parity_out;
    logic                  r_tx_active;
    logic                  r_tx_done;

    entry_t                w_wr_entry;
    entry_t                w_rd_entry;
    logic [3:0]            w_len;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_bit_end;
    logic                  w_last_stop;
    logic                  w_line;
    logic [DATA_WIDTH-1:0] w_mask;
    logic                  w_par_en;
    logic                  w_par_bit;

    always_comb begin
        w_len = i_data_length;
        if (i_data_length < LEN_MIN) begin
            w_len = LEN_MIN;
        end else if (i_data_length > LEN_MAX) begin
            w_len = LEN_MAX;
        end
    end

    assign w_wr_entry  = '{stop2: i_stop_bits, par: i_parity_type, len: w_len, data: i_data_in};
    assign w_rd_entry  = r_mem[r_rd_ptr];
    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_bit_end   = (r_timer == TIMER_MAX);
    assign w_last_stop = (r_state == S_STOP) && w_bit_end && (r_stop_cnt == r_two_stop);
    // Popping on the final stop cycle lets the next start bit follow with no idle gap.
    assign w_pop       = !w_empty && ((r_state == S_IDLE) || w_last_stop);
    assign w_push      = i_send && (!w_full || w_pop);

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_mask[i] = (4'(i) < w_rd_entry.len);
        end
        w_par_en  = (w_rd_entry.par == 2'b01) || (w_rd_entry.par == 2'b10);
        w_par_bit = (^(w_rd_entry.data & w_mask)) ^ (w_rd_entry.par == 2'b01);
    end

    always_comb begin
        w_line = 1'b1;
        case (r_state)
            S_START:  w_line = 1'b0;
            S_DATA:   w_line = r_shift[0];
            S_PARITY: w_line = r_p_parity_out;
            default:  w_line = 1'b1;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge i_clock or negedge i_rst) begin
        if (!i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
            r_overflow <= i_send && !w_push;
        end
    end

    // Line outputs are registered from the current state, so they trail the FSM by one cycle.
    always_ff @(posedge i_clock or negedge i_rst) begin
        if (!i_rst) begin
            r_state        <= S_IDLE;
            r_timer        <= '0;
            r_bit_cnt      <= '0;
            r_len          <= LEN_MIN;
            r_shift        <= '0;
            r_par_en       <= 1'b0;
            r_two_stop     <= 1'b0;
            r_stop_cnt     <= 1'b0;
            r_data_out     <= 1'b1;
            r_p_parity_out <= 1'b0;
            r_tx_active    <= 1'b0;
            r_tx_done      <= 1'b0;
        end else begin
            r_data_out  <= w_line;
            r_tx_active <= (r_state != S_IDLE);
            r_tx_done   <= w_last_stop;
            r_timer     <= ((r_state == S_IDLE) || w_bit_end) ? '0 : r_timer + 1'b1;
            if (w_pop) begin
                r_state        <= S_START;
                r_shift        <= w_rd_entry.data;
                r_len          <= w_rd_entry.len;
                r_par_en       <= w_par_en;
                r_two_stop     <= w_rd_entry.stop2;
                r_p_parity_out <= w_par_en & w_par_bit;
                r_bit_cnt      <= '0;
                r_stop_cnt     <= 1'b0;
            end else if (w_bit_end) begin
                case (r_state)
                    S_START: r_state <= S_DATA;
                    S_DATA: begin
                        r_shift <= r_shift >> 1;
                        if (r_bit_cnt == r_len - 4'd1) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_par_en ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                    S_PARITY: r_state <= S_STOP;
                    S_STOP: begin
                        if (r_stop_cnt == r_two_stop) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_data_out     = r_data_out;
    assign o_p_parity_out = r_p_parity_out;
    assign o_tx_active    = r_tx_active;
    assign o_tx_done      = r_tx_done;
    assign o_fifo_full    = w_full;
    assign o_fifo_empty   = w_empty;
    assign o_fifo_count   = r_count;
    assign o_overflow     = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
// Randomised bench for uart_tx_fifo: expected frames are queued at send time and a line monitor
// decodes every frame on data_out and compares it bit-period by bit-period.
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send = 1'b0;
    logic [7:0] data_in = '0;
    logic [3:0] data_length = '0;
    logic [1:0] parity_type = '0;
    logic       stop_bits = 1'b0;
    logic       data_out, p_parity_out, tx_active, tx_done, fifo_full, fifo_empty, overflow;
    logic [2:0] fifo_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_done  = 0;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        logic        pbit;
    } exp_t;

    exp_t exp_q[$];
    int   start_log[$];

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .i_clock(clk), .i_rst(rst), .i_send(send), .i_data_in(data_in),
        .i_data_length(data_length), .i_parity_type(parity_type), .i_stop_bits(stop_bits),
        .o_data_out(data_out), .o_p_parity_out(p_parity_out), .o_tx_active(tx_active),
        .o_tx_done(tx_done), .o_fifo_full(fifo_full), .o_fifo_empty(fifo_empty),
        .o_fifo_count(fifo_count), .o_overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rst && tx_done === 1'b1) n_done++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Frame as a list of line levels, one per bit period, built directly from the format rules.
    function automatic exp_t model(input logic [7:0] d, input logic [3:0] l, input logic [1:0] p, input logic s);
        exp_t e;
        int   len;
        int   ones;
        logic pb;
        bit   pen;
        len = l;
        if (len < 5) len = 5;
        if (len > DW) len = DW;
        ones    = 0;
        e.bits  = '1;
        e.bits[0] = 1'b0;
        e.nbits = 1;
        for (int i = 0; i < len; i++) begin
            e.bits[e.nbits] = d[i];
            ones += int'(d[i]);
            e.nbits++;
        end
        pen = (p == 2'b01) || (p == 2'b10);
        pb  = (p == 2'b01) ? (ones % 2 == 0) : (ones % 2 == 1);
        if (pen) begin
            e.bits[e.nbits] = pb;
            e.nbits++;
        end
        e.nbits += s ? 2 : 1;
        e.pbit   = pen ? pb : 1'b0;
        return e;
    endfunction

    task automatic put(input logic [7:0] d, input logic [3:0] l, input logic [1:0] p, input logic s, input bit acc);
        send = 1'b1; data_in = d; data_length = l; parity_type = p; stop_bits = s;
        if (acc) exp_q.push_back(model(d, l, p, s));
    endtask

    task automatic idle_inputs();
        send = 1'b0;
        data_in = 8'($urandom); data_length = 4'($urandom); parity_type = 2'($urandom); stop_bits = 1'($urandom);
    endtask

    task automatic send_word(input logic [7:0] d, input logic [3:0] l, input logic [1:0] p, input logic s,
                             output int edge_cyc);
        @(negedge clk);
        put(d, l, p, s, 1'b1);
        edge_cyc = cyc + 1;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || tx_active !== 1'b0 || fifo_empty !== 1'b1) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk(name, t < 3000, 1);
        repeat (3) @(negedge clk);
    endtask

    // Line monitor: any low level while idle starts a frame, which must match the queue head.
    initial begin
        exp_t e;
        int   line_err, ctl_err, last;
        bit   aborted;
        forever begin
            @(negedge clk);
            if (rst && data_out === 1'b0) begin
                chk("frame_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    start_log.push_back(cyc);
                    chk("parity_out", p_parity_out, e.pbit);
                    line_err = 0; ctl_err = 0; aborted = 0;
                    last = e.nbits * CPB - 1;
                    for (int k = 0; k <= last; k++) begin
                        if (k > 0) @(negedge clk);
                        if (!rst) begin
                            aborted = 1;
                            break;
                        end
                        if (data_out !== e.bits[k / CPB]) line_err++;
                        if (tx_active !== 1'b1 || tx_done !== (k == last)) ctl_err++;
                    end
                    if (!aborted) begin
                        chk("frame_line", line_err, 0);
                        chk("frame_ctl", ctl_err, 0);
                    end
                end
            end
        end
    end

    initial begin
        int   n0, k0, e_cyc, t;
        exp_t m[3];
        logic [7:0] d;
        logic [3:0] l;
        logic [1:0] p;
        logic       s;

        #2 rst = 1'b0;
        #1;
        chk("rst_data_out", data_out, 1);
        chk("rst_tx_active", tx_active, 0);
        chk("rst_tx_done", tx_done, 0);
        chk("rst_fifo_empty", fifo_empty, 1);
        chk("rst_fifo_full", fifo_full, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_parity_out", p_parity_out, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);

        // 8-bit odd parity, also checks send-to-start latency
        n0 = n_done; k0 = start_log.size();
        send_word(8'b10010110, 4'd8, 2'b01, 1'b0, e_cyc);
        wait_idle("idle_odd8");
        chk("frame_seen_odd8", start_log.size() - k0, 1);
        if (start_log.size() > k0) chk("latency_start", start_log[k0] - e_cyc, 2);
        chk("done_odd8", n_done - n0, 1);

        n0 = n_done;
        send_word(8'b10010110, 4'd7, 2'b10, 1'b1, e_cyc);
        wait_idle("idle_even7");
        chk("done_even7", n_done - n0, 1);

        n0 = n_done;
        send_word(8'h1F, 4'd3, 2'b00, 1'b0, e_cyc);
        wait_idle("idle_len_clamp");
        chk("done_len_clamp", n_done - n0, 1);

        send_word(8'hC3, 4'd15, 2'b11, 1'b1, e_cyc);
        wait_idle("idle_par11");

        // Reset in the middle of a frame with a second word queued
        n0 = n_done;
        send_word(8'hA5, 4'd8, 2'b10, 1'b1, e_cyc);
        repeat (12) @(negedge clk);
        send_word(8'h3C, 4'd6, 2'b01, 1'b0, e_cyc);
        chk("count_before_reset", fifo_count, 1);
        #2 rst = 1'b0;
        #1;
        chk("abort_data_out", data_out, 1);
        chk("abort_tx_active", tx_active, 0);
        chk("abort_fifo_empty", fifo_empty, 1);
        chk("abort_fifo_count", fifo_count, 0);
        exp_q.delete();
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (150) @(negedge clk);
        chk("no_done_after_abort", n_done - n0, 0);
        chk("line_idle_after_abort", data_out, 1);

        // Three back-to-back words must form contiguous frames
        n0 = n_done; k0 = start_log.size();
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom); l = 4'($urandom); p = 2'($urandom); s = 1'($urandom);
            m[i] = model(d, l, p, s);
            @(negedge clk);
            put(d, l, p, s, 1'b1);
        end
        @(negedge clk);
        idle_inputs();
        wait_idle("idle_b2b");
        chk("b2b_frames", start_log.size() - k0, 3);
        chk("b2b_done", n_done - n0, 3);
        if (start_log.size() >= k0 + 3) begin
            chk("b2b_gap01", start_log[k0 + 1] - start_log[k0], m[0].nbits * CPB);
            chk("b2b_gap12", start_log[k0 + 2] - start_log[k0 + 1], m[1].nbits * CPB);
        end

        // Overflow: five sends while busy, the fifth must be dropped
        send_word(8'h81, 4'd8, 2'b01, 1'b1, e_cyc);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 4) begin
                chk("full_before_5th", fifo_full, 1);
                chk("count_full", fifo_count, 4);
                chk("no_overflow_yet", overflow, 0);
            end
            put(8'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), i < 4);
        end
        @(negedge clk);
        idle_inputs();
        chk("overflow_pulse", overflow, 1);
        chk("count_after_drop", fifo_count, 4);
        @(negedge clk);
        chk("overflow_single", overflow, 0);
        wait_idle("idle_overflow");

        // Random traffic, never exceeding FIFO space
        for (int w = 0; w < 24; w++) begin
            t = 0;
            while (exp_q.size() >= DEPTH && t < 2000) begin
                @(negedge clk);
                t++;
            end
            chk("rand_space", t < 2000, 1);
            send_word(8'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), e_cyc);
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        wait_idle("idle_random");
        chk("leftover_expected", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
